button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 92160; stable-input cycles required before accepting a change (5 ms at 18.432 MHz).
REQ-002 Parameter LONG_CYCLES, default 18432000; held cycles, counted from press acceptance, before a long-press pulse (1 s at 18.432 MHz).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 means pressed = btn_in low.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  raw asynchronous button pin.
REQ-007 level  output  1  debounced pressed state, 1 = pressed.
REQ-008 press  output  1  one-cycle pulse on accepted press.
REQ-009 release  output  1  one-cycle pulse on accepted release.
REQ-010 long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES (see Configuration).

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer, then be polarity-normalised per ACTIVE_LOW to give s (1 = pressed).
REQ-012 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: s=1 -> PRESS_WAIT with debounce counter cleared; otherwise stay.
REQ-014 PRESS_WAIT: s=0 -> IDLE (bounce rejected, no pulse); counter == DEBOUNCE_CYCLES-1 with s=1 -> HELD, press=1 for that cycle; otherwise increment.
REQ-015 HELD: s=0 -> RELEASE_WAIT with counter cleared; otherwise stay.
REQ-016 RELEASE_WAIT: s=1 -> HELD (no pulse, long counter not reset); counter == DEBOUNCE_CYCLES-1 with s=0 -> IDLE, release=1; otherwise increment.
REQ-017 level SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-018 Latency: a clean btn_in step SHALL produce press/release DEBOUNCE_CYCLES+2 clock edges after the first edge sampling the new value.
REQ-019 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits minimum; it SHALL never wrap.
REQ-020 press and release SHALL never assert in the same cycle; each pulse lasts exactly one cycle.
REQ-021 DEBOUNCE_CYCLES=1 SHALL be legal: transition on the cycle after entering a WAIT state.

Reset
REQ-022 On reset=1 at a clock edge: state=IDLE, both counters=0, synchronizer flops=not-pressed, level=0, press=0, release=0, long_press=0.
REQ-023 Reset asserted mid-press SHALL abort without any release pulse; a still-pressed button SHALL then re-debounce from IDLE.

Configuration
REQ-024 Macro BUTTON_DEBOUNCE_LONG_PRESS_EN: when defined, long counter starts at 0 on press acceptance, increments in HELD and RELEASE_WAIT, saturates at LONG_CYCLES-1, and pulses long_press once when it reaches LONG_CYCLES-1; it clears on return to IDLE.
REQ-025 Without the macro: long counter is absent; long_press is tied to 0.

Structure
REQ-026 Package button_debounce_pkg SHALL hold the FSM state encoding (2-bit) and a counter-width helper constant/function.
REQ-027 Sub-module sync2 SHALL implement the two-flop synchronizer, with reset value as a parameter.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, macro defined)
REQ-028 Reset 3 cycles, btn_in=1 -> level=0, press/release/long_press=0 throughout.
REQ-029 btn_in 1->0 held -> press high for exactly one cycle, 6 edges after the change; level=1 from the same cycle.
REQ-030 btn_in low 2 cycles then high (bounce) -> no press, level stays 0, FSM back in IDLE.
REQ-031 Held press, release glitch of 2 cycles -> level stays 1, no release pulse; a clean release then gives release 6 edges later.
REQ-032 Held 30 cycles past press -> exactly one long_press, 19 cycles after press; no further pulses; without macro, long_press=0.
REQ-033 reset asserted while level=1 -> all outputs 0 next cycle, no release pulse; button still held -> press again 6 edges after reset deasserts.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared FSM encoding and counter sizing for button_debounce.
`default_nettype none

package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed for a counter that runs 0..cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is configurable.
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// Button debouncer with press/release pulses; optional long-press pulse
// enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
`default_nettype none

module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 92160,
  parameter int LONG_CYCLES     = 18432000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,  // "release" is a reserved word in SystemVerilog
  output logic long_press
);

  localparam int             DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_PIN = (ACTIVE_LOW != 0);

  logic            pin_sync;
  logic            s;
  state_t          state, state_nxt;
  logic [DW-1:0]   cnt, cnt_nxt;
  logic            press_nxt, release_nxt;

  sync2 #(.RESET_VAL(IDLE_PIN)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (pin_sync)
  );

  assign s     = (ACTIVE_LOW != 0) ? ~pin_sync : pin_sync;
  assign level = (state == HELD) || (state == RELEASE_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // The counter only advances while below DB_LAST, so it can never wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int            LW        = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          long_nxt;

  // Hold time is measured from press acceptance and survives release glitches.
  always_comb begin
    lcnt_nxt = lcnt;
    long_nxt = 1'b0;
    if (press_nxt) begin
      lcnt_nxt = '0;
      long_nxt = (LONG_LAST == '0);
    end else if (state_nxt == IDLE) begin
      lcnt_nxt = '0;
    end else if (level && (lcnt != LONG_LAST)) begin
      lcnt_nxt = lcnt + 1'b1;
      long_nxt = ((lcnt + 1'b1) == LONG_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      lcnt       <= lcnt_nxt;
      long_press <= long_nxt;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bursts against a run-length model.
`default_nettype none

module tb_button_debounce;

  localparam int N = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic level, press, release_pulse, long_press;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (N),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  // Model: pressed level seen through two sample delays; a level change is
  // accepted after N+1 consecutive edges that see the opposite value.
  bit p1, p2, m_level, m_press, m_rel, m_long;
  int run, hold;
  int tests, fails, cyc;
  int press_cnt, rel_cnt, long_cnt, last_press, last_rel, last_long;

  task automatic model_edge(input logic b, input logic r);
    bit s;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (r) begin
      p1 = 1'b0; p2 = 1'b0; m_level = 1'b0; run = 0; hold = 0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = ~b;
      run = (s != m_level) ? run + 1 : 0;
      if (run == N + 1) begin
        m_level = s;
        run     = 0;
        hold    = 0;
        if (s) begin
          m_press = 1'b1;
          m_long  = (L == 1);
        end else begin
          m_rel = 1'b1;
        end
      end else if (m_level && hold < L - 1) begin
        hold++;
        m_long = (hold == L - 1);
      end
    end
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    m_long = 1'b0;
`endif
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    reset  = r;
    btn_in = b;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check("level", level, m_level);
    check("press", press, m_press);
    check("release", release_pulse, m_rel);
    check("long_press", long_press, m_long);
    check("press_and_release", press & release_pulse, 1'b0);
    if (press === 1'b1) begin press_cnt++; last_press = cyc; end
    if (release_pulse === 1'b1) begin rel_cnt++; last_rel = cyc; end
    if (long_press === 1'b1) begin long_cnt++; last_long = cyc; end
    cyc++;
  endtask

  task automatic repeat_step(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int t0, pc, rc;
    reset = 1'b1;
    btn_in = 1'b1;

    // Reset with button released
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk_int("reset_level", level, 0);
    repeat_step(1'b1, 2);

    // Clean press, held long enough for the long-press pulse
    t0 = cyc;
    repeat_step(1'b0, 40);
    chk_int("press_count", press_cnt, 1);
    chk_int("press_delay", last_press - t0, 6);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    chk_int("long_count", long_cnt, 1);
    chk_int("long_delay", last_long - last_press, 19);
`else
    chk_int("long_count", long_cnt, 0);
`endif

    // Release glitch must be rejected
    repeat_step(1'b1, 2);
    repeat_step(1'b0, 8);
    chk_int("glitch_release_count", rel_cnt, 0);
    chk_int("glitch_level", level, 1);

    // Clean release
    t0 = cyc;
    repeat_step(1'b1, 10);
    chk_int("release_count", rel_cnt, 1);
    chk_int("release_delay", last_rel - t0, 6);
    chk_int("long_after_release", long_cnt, (long_cnt > 0) ? 1 : 0);

    // Press bounce must be rejected
    repeat_step(1'b0, 2);
    repeat_step(1'b1, 10);
    chk_int("bounce_press_count", press_cnt, 1);
    chk_int("bounce_level", level, 0);

    // Reset while held, then re-debounce with button still down
    repeat_step(1'b0, 10);
    chk_int("held_before_reset", level, 1);
    pc = press_cnt;
    rc = rel_cnt;
    step(1'b0, 1'b1);
    chk_int("reset_abort_level", level, 0);
    t0 = cyc;
    repeat_step(1'b0, 10);
    chk_int("reset_no_release", rel_cnt, rc);
    chk_int("repress_count", press_cnt, pc + 1);
    chk_int("repress_delay", last_press - t0, 6);
    repeat_step(1'b1, 10);

    // Random bursts of mixed lengths with occasional reset
    for (int k = 0; k < 300; k++) begin
      logic b, r;
      int len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      r   = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < len; i++) step(b, r && (i == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
